// File: rtl/mem_arbiter_if.sv
// Request/response bundle linking the fetch and load/store requesters, the arbiter
// and the byte-serial MemoryController.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              i_done;
  logic [31:0]       i_data;
  logic              d_req;
  logic              d_wr;
  logic [2:0]        d_len;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_done;
  logic [31:0]       d_data;
  logic              mc_start;
  logic              mc_wr;
  logic [2:0]        mc_len;
  logic [ADDR_W-1:0] mc_addr;
  logic [31:0]       mc_wdata;
  logic              mc_done;
  logic [31:0]       mc_rdata;

  // Arbiter view
  modport slave (
    input  i_req, i_addr, i_flush, d_req, d_wr, d_len, d_addr, d_wdata, mc_done, mc_rdata,
    output i_done, i_data, d_done, d_data, mc_start, mc_wr, mc_len, mc_addr, mc_wdata
  );

  // Requester and MemoryController view
  modport master (
    output i_req, i_addr, i_flush, d_req, d_wr, d_len, d_addr, d_wdata, mc_done, mc_rdata,
    input  i_done, i_data, d_done, d_data, mc_start, mc_wr, mc_len, mc_addr, mc_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-serial MemoryController between instruction fetches and data
// loads/stores, one transaction at a time, with flush cancellation of fetches.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter bit          FAIR   = 1'b1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  mem_arbiter_if.slave bus
);

  localparam int unsigned LEN_W     = 3;
  localparam logic [LEN_W-1:0] FETCH_LEN = LEN_W'(4);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

  state_t            state;
  logic              last_grant_d;
  logic              killed;
  logic              mc_start_q;
  logic              mc_wr_q;
  logic [LEN_W-1:0]  mc_len_q;
  logic [ADDR_W-1:0] mc_addr_q;
  logic [31:0]       mc_wdata_q;
  logic              i_done_q;
  logic              d_done_q;
  logic [31:0]       i_data_q;
  logic [31:0]       d_data_q;

  logic i_cand;
  logic grant_d;
  logic grant_i;

  // A flushed fetch is not a candidate; on a tie FAIR alternates, otherwise data wins
  always_comb begin
    i_cand  = bus.i_req && !bus.i_flush;
    grant_d = bus.d_req && (!i_cand || !FAIR || !last_grant_d);
    grant_i = i_cand && !grant_d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      killed       <= 1'b0;
      mc_start_q   <= 1'b0;
      mc_wr_q      <= 1'b0;
      mc_len_q     <= '0;
      mc_addr_q    <= '0;
      mc_wdata_q   <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_data_q     <= '0;
      d_data_q     <= '0;
    end else if (rdy_in) begin
      mc_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mc_wr_q      <= bus.d_wr;
            mc_len_q     <= bus.d_len;
            mc_addr_q    <= bus.d_addr;
            mc_wdata_q   <= bus.d_wdata;
            mc_start_q   <= 1'b1;
            last_grant_d <= 1'b1;
            state        <= D_BUSY;
          end else if (grant_i) begin
            mc_wr_q      <= 1'b0;
            mc_len_q     <= FETCH_LEN;
            mc_addr_q    <= bus.i_addr;
            mc_wdata_q   <= '0;
            mc_start_q   <= 1'b1;
            last_grant_d <= 1'b0;
            state        <= I_BUSY;
          end
        end
        I_BUSY: begin
          // A flush seen at any point, even alongside mc_done, swallows the result
          if (bus.mc_done) begin
            if (killed || bus.i_flush) begin
              killed <= 1'b0;
              state  <= IDLE;
            end else begin
              i_data_q <= bus.mc_rdata;
              i_done_q <= 1'b1;
              state    <= RESP;
            end
          end else if (bus.i_flush) begin
            killed <= 1'b1;
          end
        end
        D_BUSY: begin
          if (bus.mc_done) begin
            if (!mc_wr_q) d_data_q <= bus.mc_rdata;
            d_done_q <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          i_done_q <= 1'b0;
          d_done_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The start pulse stays pending across stalls so the MC sees it exactly once
  assign bus.mc_start = mc_start_q && rdy_in;
  assign bus.mc_wr    = mc_wr_q;
  assign bus.mc_len   = mc_len_q;
  assign bus.mc_addr  = mc_addr_q;
  assign bus.mc_wdata = mc_wdata_q;
  assign bus.i_done   = i_done_q;
  assign bus.i_data   = i_data_q;
  assign bus.d_done   = d_done_q;
  assign bus.d_data   = d_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a byte-addressed memory model plays the
// MemoryController and a grant-history model predicts arbitration order.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  int n_tests   = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int done_cnt  = 0;

  logic [7:0]  mem [logic [31:0]];
  bit          model_last_d;
  logic [31:0] model_i_data;
  logic [31:0] model_d_data;

  mem_arbiter_if #(.ADDR_W(AW)) bus   ();
  mem_arbiter_if #(.ADDR_W(AW)) bus_p ();

  mem_arbiter #(.ADDR_W(AW), .FAIR(1'b1)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  // Priority-to-data twin, fed the same inputs
  mem_arbiter #(.ADDR_W(AW), .FAIR(1'b0)) dut_p (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus_p)
  );

  assign bus_p.i_req    = bus.i_req;
  assign bus_p.i_addr   = bus.i_addr;
  assign bus_p.i_flush  = bus.i_flush;
  assign bus_p.d_req    = bus.d_req;
  assign bus_p.d_wr     = bus.d_wr;
  assign bus_p.d_len    = bus.d_len;
  assign bus_p.d_addr   = bus.d_addr;
  assign bus_p.d_wdata  = bus.d_wdata;
  assign bus_p.mc_done  = bus.mc_done;
  assign bus_p.mc_rdata = bus.mc_rdata;

  always #5 clk_in = ~clk_in;

  // Handshakes as the MC and requesters would accept them
  always @(posedge clk_in) begin
    if (rdy_in && bus.mc_start) start_cnt++;
    if (rdy_in && (bus.i_done || bus.d_done)) done_cnt++;
  end

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0] ^ 8'hA5;
    if (mem.exists(a)) b = mem[a];
    return b;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] len);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < int'(len) && k < 4; k++) v[8*k +: 8] = byte_at(a + 32'(k));
    return v;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [2:0] len, input logic [31:0] v);
    for (int k = 0; k < int'(len) && k < 4; k++) mem[a + 32'(k)] = v[8*k +: 8];
  endtask

  function automatic logic [2:0] pick_len();
    logic [2:0] l;
    case ($urandom_range(0, 3))
      0:       l = 3'd1;
      1:       l = 3'd2;
      2:       l = 3'd4;
      default: l = 3'd3;
    endcase
    return l;
  endfunction

  task automatic clear_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0; bus.i_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_len = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mc_done = 1'b0; bus.mc_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk_in);
    rst_in       = 1'b0;
    model_last_d = 1'b1;
    model_i_data = '0;
    model_d_data = '0;
  endtask

  task automatic set_data(input logic wr, input logic [2:0] len, input logic [31:0] a,
                          input logic [31:0] wd);
    bus.d_req = 1'b1; bus.d_wr = wr; bus.d_len = len; bus.d_addr = a; bus.d_wdata = wd;
  endtask

  // Launch, MC latency, response pulse and the idle cycle after it
  task automatic serve(input bit exp_d, input int unsigned lat, input bit chk_p);
    logic [67:0] exp_f;
    logic [67:0] got_f;
    logic [31:0] rd;
    logic        ewr;
    logic [2:0]  el;
    logic [31:0] ea;
    ewr   = exp_d ? bus.d_wr : 1'b0;
    el    = exp_d ? bus.d_len : 3'd4;
    ea    = exp_d ? bus.d_addr : bus.i_addr;
    exp_f = {ewr, el, ea, exp_d ? bus.d_wdata : 32'h0};
    @(negedge clk_in);
    got_f = {bus.mc_wr, bus.mc_len, bus.mc_addr, exp_d ? bus.mc_wdata : 32'h0};
    n_tests++;
    if (bus.mc_start !== 1'b1 || got_f !== exp_f) begin
      n_fail++;
      $display("FAIL launch(%s): start=%b fields=%h, expected start=1 fields=%h",
               exp_d ? "data" : "fetch", bus.mc_start, got_f, exp_f);
    end
    if (chk_p) begin
      n_tests++;
      if ({bus_p.mc_start, bus_p.mc_wr, bus_p.mc_len, bus_p.mc_addr} !==
          {1'b1, bus.d_wr, bus.d_len, bus.d_addr}) begin
        n_fail++;
        $display("FAIL prio_data_first: start=%b addr=%h len=%0d, expected start=1 addr=%h len=%0d",
                 bus_p.mc_start, bus_p.mc_addr, bus_p.mc_len, bus.d_addr, bus.d_len);
      end
    end
    repeat (lat) begin
      @(negedge clk_in);
      if (exp_d) bus.i_flush = 1'($urandom_range(0, 1));
      got_f = {bus.mc_wr, bus.mc_len, bus.mc_addr, exp_d ? bus.mc_wdata : 32'h0};
      n_tests++;
      if (bus.mc_start !== 1'b0 || got_f !== exp_f) begin
        n_fail++;
        $display("FAIL hold: start=%b fields=%h, expected start=0 fields=%h",
                 bus.mc_start, got_f, exp_f);
      end
    end
    bus.i_flush = 1'b0;
    rd = (exp_d && ewr) ? 32'($urandom()) : mem_rd(ea, el);
    if (exp_d && ewr) mem_wr(ea, el, bus.d_wdata);
    bus.mc_done  = 1'b1;
    bus.mc_rdata = rd;
    @(negedge clk_in);
    bus.mc_done  = 1'b0;
    bus.mc_rdata = 32'($urandom());
    if (!exp_d) model_i_data = rd;
    else if (!ewr) model_d_data = rd;
    n_tests++;
    if ({bus.i_done, bus.d_done} !== (exp_d ? 2'b01 : 2'b10) ||
        bus.i_data !== model_i_data || bus.d_data !== model_d_data) begin
      n_fail++;
      $display("FAIL response: i_done=%b d_done=%b i_data=%h d_data=%h, expected i_done=%b d_done=%b i_data=%h d_data=%h",
               bus.i_done, bus.d_done, bus.i_data, bus.d_data, !exp_d, exp_d, model_i_data, model_d_data);
    end
    if (exp_d) bus.d_req = 1'b0;
    else       bus.i_req = 1'b0;
    model_last_d = exp_d;
    @(negedge clk_in);
    n_tests++;
    if ({bus.i_done, bus.d_done, bus.mc_start} !== 3'b000) begin
      n_fail++;
      $display("FAIL pulse_width: i_done=%b d_done=%b mc_start=%b, expected all 0",
               bus.i_done, bus.d_done, bus.mc_start);
    end
  endtask

  task automatic test_reset();
    logic [134:0] outs;
    @(negedge clk_in);
    outs = {bus.i_done, bus.i_data, bus.d_done, bus.d_data, bus.mc_start, bus.mc_wr,
            bus.mc_len, bus.mc_addr, bus.mc_wdata};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0", outs);
    end
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_1000;
    @(negedge clk_in);
    n_tests++;
    if (bus.mc_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_grant: mc_start=%b, expected 0", bus.mc_start);
    end
    bus.i_req = 1'b0;
  endtask

  task automatic test_fetch();
    do_reset();
    mem_wr(32'h0000_1000, 3'd4, 32'hDEAD_BEEF);
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_1000;
    serve(1'b0, 4, 1'b0);
    n_tests++;
    if (bus.i_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL fetch_word: i_data=%h, expected deadbeef", bus.i_data);
    end
  endtask

  task automatic test_fair();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      bus.i_req = 1'b1; bus.i_addr = 32'($urandom()) & 32'hFFFF_FFFC;
      set_data(1'b0, 3'd2, (r == 0) ? 32'h0000_2004 : 32'($urandom()), 32'($urandom()));
      serve(1'b0, $urandom_range(1, 4), 1'b1);
      serve(1'b1, $urandom_range(1, 4), 1'b0);
    end
  endtask

  task automatic test_store();
    do_reset();
    set_data(1'b0, 3'd4, 32'h0000_2000, 32'h0);
    serve(1'b1, 2, 1'b0);
    set_data(1'b1, 3'd1, 32'h0003_0000, 32'h0000_0041);
    serve(1'b1, 3, 1'b0);
    set_data(1'b0, 3'd1, 32'h0003_0000, 32'h0);
    serve(1'b1, 1, 1'b0);
    n_tests++;
    if (bus.d_data !== 32'h0000_0041) begin
      n_fail++;
      $display("FAIL store_readback: d_data=%h, expected 00000041", bus.d_data);
    end
  endtask

  task automatic test_flush();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      bus.i_req = 1'b1; bus.i_addr = 32'($urandom()) & 32'hFFFF_FFFC;
      @(negedge clk_in);
      n_tests++;
      if (bus.mc_start !== 1'b1 || bus.mc_addr !== bus.i_addr || bus.mc_len !== 3'd4) begin
        n_fail++;
        $display("FAIL flush_launch: start=%b addr=%h len=%0d, expected 1 %h 4",
                 bus.mc_start, bus.mc_addr, bus.mc_len, bus.i_addr);
      end
      set_data(1'b0, pick_len(), 32'($urandom()), 32'h0);
      @(negedge clk_in);
      @(negedge clk_in);
      if (v == 0) begin
        bus.i_flush = 1'b1;
        @(negedge clk_in);
        bus.i_flush = 1'b0; bus.i_req = 1'b0;
        @(negedge clk_in);
      end else begin
        bus.i_flush = 1'b1;
      end
      bus.mc_done = 1'b1; bus.mc_rdata = 32'($urandom());
      @(negedge clk_in);
      bus.mc_done = 1'b0; bus.i_flush = 1'b0; bus.i_req = 1'b0;
      n_tests++;
      if ({bus.i_done, bus.d_done} !== 2'b00 || bus.i_data !== model_i_data) begin
        n_fail++;
        $display("FAIL flush_kill(%0d): i_done=%b d_done=%b i_data=%h, expected 0 0 %h",
                 v, bus.i_done, bus.d_done, bus.i_data, model_i_data);
      end
      model_last_d = 1'b0;
      serve(1'b1, $urandom_range(1, 3), 1'b0);
    end
  endtask

  task automatic test_rdy_stall();
    int s0;
    int c0;
    logic [31:0] rd;
    do_reset();
    set_data(1'b0, 3'd4, 32'($urandom()), 32'h0);
    s0 = start_cnt; c0 = done_cnt;
    @(negedge clk_in);
    n_tests++;
    if (bus.mc_start !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_launch: mc_start=%b, expected 1", bus.mc_start);
    end
    @(negedge clk_in);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      bus.mc_done  = (k == 0);
      bus.mc_rdata = 32'hBAD0_BAD0;
      n_tests++;
      if (bus.mc_start !== 1'b0 || bus.mc_addr !== bus.d_addr || bus.d_done !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_busy: mc_start=%b mc_addr=%h d_done=%b, expected 0 %h 0",
                 bus.mc_start, bus.mc_addr, bus.d_done, bus.d_addr);
      end
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    rd = mem_rd(bus.d_addr, 3'd4);
    bus.mc_done = 1'b1; bus.mc_rdata = rd;
    @(negedge clk_in);
    bus.mc_done = 1'b0;
    n_tests++;
    if (bus.d_done !== 1'b1 || bus.d_data !== rd) begin
      n_fail++;
      $display("FAIL stall_resp: d_done=%b d_data=%h, expected 1 %h", bus.d_done, bus.d_data, rd);
    end
    rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      n_tests++;
      if (bus.d_done !== 1'b1 || bus.mc_start !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_resp_frozen: d_done=%b mc_start=%b, expected 1 0", bus.d_done, bus.mc_start);
      end
    end
    rdy_in = 1'b1; bus.d_req = 1'b0;
    @(negedge clk_in);
    n_tests++;
    if (bus.d_done !== 1'b0 || (start_cnt - s0) != 1 || (done_cnt - c0) != 1) begin
      n_fail++;
      $display("FAIL stall_counts: d_done=%b starts=%0d dones=%0d, expected 0 1 1",
               bus.d_done, start_cnt - s0, done_cnt - c0);
    end
    model_d_data = rd;
  endtask

  task automatic test_reset_mid();
    logic [134:0] outs;
    do_reset();
    set_data(1'b0, 3'd4, 32'($urandom()), 32'h0);
    serve(1'b1, 2, 1'b0);
    bus.i_req = 1'b1; bus.i_addr = 32'($urandom()) | 32'h4;
    @(negedge clk_in);
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    outs = {bus.i_done, bus.i_data, bus.d_done, bus.d_data, bus.mc_start, bus.mc_wr,
            bus.mc_len, bus.mc_addr, bus.mc_wdata};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL async_reset: outputs=%h, expected 0", outs);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    model_last_d = 1'b1; model_i_data = '0; model_d_data = '0;
    serve(1'b0, $urandom_range(1, 4), 1'b0);
  endtask

  task automatic test_random_traffic();
    bit first_d;
    int mode;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
      mode = $urandom_range(0, 3);
      if (mode != 1) begin
        bus.i_req = 1'b1; bus.i_addr = 32'($urandom()) & 32'hFFFF_FFFC;
      end
      if (mode != 0)
        set_data(1'($urandom_range(0, 1)), pick_len(), 32'($urandom()), 32'($urandom()));
      if (mode == 3) bus.i_flush = 1'b1;
      case (mode)
        0:       first_d = 1'b0;
        1:       first_d = 1'b1;
        2:       first_d = !model_last_d;
        default: first_d = 1'b1;
      endcase
      serve(first_d, $urandom_range(1, 5), 1'b0);
      if (mode >= 2) serve(!first_d, $urandom_range(1, 5), 1'b0);
    end
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch();
    test_fair();
    test_store();
    test_flush();
    test_rdy_stall();
    test_reset_mid();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
